// File: rtl/pdm_demod.sv
// pdm_demod: decimating PDM receiver.
// Counts ones over a window of 2^DEC_LOG2 qualified bits and presents the
// saturated count on a valid/ready output with a sticky overrun flag.
// sync restarts the window. The bit qualified in the sync cycle is the first
// bit of the new window.
module pdm_demod #(
   parameter int DEC_LOG2 = 5
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                pdm_in,
   input  logic                pdm_valid,
   input  logic                sync,
   output logic [DEC_LOG2-1:0] sample_out,
   output logic                sample_valid,
   input  logic                sample_ready,
   output logic                overrun
);

   localparam logic [DEC_LOG2-1:0] WIN_LAST  = {DEC_LOG2{1'b1}};
   localparam logic [DEC_LOG2-1:0] WIN_ZERO  = {DEC_LOG2{1'b0}};
   localparam logic [DEC_LOG2-1:0] WIN_ONE   = {{(DEC_LOG2-1){1'b0}}, 1'b1};
   localparam logic [DEC_LOG2:0]   ONES_ZERO = {(DEC_LOG2+1){1'b0}};

   logic [DEC_LOG2-1:0] win_cnt_q,  win_cnt_d;
   logic [DEC_LOG2:0]   ones_cnt_q, ones_cnt_d;
   logic [DEC_LOG2-1:0] sample_q,   sample_d;
   logic                valid_q,    valid_d;
   logic                ovr_q,      ovr_d;

   logic [DEC_LOG2:0]   total_s;
   logic [DEC_LOG2-1:0] sat_s;
   logic [DEC_LOG2:0]   pdm_ext_s;
   logic                end_win_s;

   // Window total including the current bit, saturated to the output width.
   always_comb begin
      pdm_ext_s = {{DEC_LOG2{1'b0}}, pdm_in};
      total_s   = ones_cnt_q + pdm_ext_s;
      if (total_s[DEC_LOG2]) begin
         sat_s = WIN_LAST;
      end else begin
         sat_s = total_s[DEC_LOG2-1:0];
      end
      end_win_s = pdm_valid & ~sync & (win_cnt_q == WIN_LAST);
   end

   // Window and ones counters: sync restarts the window, qualified bits advance it.
   always_comb begin
      win_cnt_d  = win_cnt_q;
      ones_cnt_d = ones_cnt_q;
      if (sync) begin
         if (pdm_valid) begin
            win_cnt_d  = WIN_ONE;
            ones_cnt_d = pdm_ext_s;
         end else begin
            win_cnt_d  = WIN_ZERO;
            ones_cnt_d = ONES_ZERO;
         end
      end else if (pdm_valid) begin
         if (end_win_s) begin
            win_cnt_d  = WIN_ZERO;
            ones_cnt_d = ONES_ZERO;
         end else begin
            win_cnt_d  = win_cnt_q + WIN_ONE;
            ones_cnt_d = total_s;
         end
      end else begin
         win_cnt_d  = win_cnt_q;
         ones_cnt_d = ones_cnt_q;
      end
   end

   // Output handshake: newest sample wins, and an unconsumed overwrite sets overrun.
   always_comb begin
      sample_d = sample_q;
      valid_d  = valid_q;
      ovr_d    = ovr_q;
      if (end_win_s) begin
         sample_d = sat_s;
         valid_d  = 1'b1;
         if (valid_q && !sample_ready) begin
            ovr_d = 1'b1;
         end else begin
            ovr_d = ovr_q;
         end
      end else if (valid_q && sample_ready) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         win_cnt_q  <= WIN_ZERO;
         ones_cnt_q <= ONES_ZERO;
         sample_q   <= WIN_ZERO;
         valid_q    <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         win_cnt_q  <= win_cnt_d;
         ones_cnt_q <= ones_cnt_d;
         sample_q   <= sample_d;
         valid_q    <= valid_d;
         ovr_q      <= ovr_d;
      end
   end

   assign sample_out   = sample_q;
   assign sample_valid = valid_q;
   assign overrun      = ovr_q;

endmodule

// File: tb/tb_pdm_demod.sv
// Self-checking bench for pdm_demod (DEC_LOG2 = 5).
// A window-count reference model is compared against the DUT on every cycle.
// Directed phases add checks on decoded values and on sample counts.
module tb_pdm_demod;

   localparam int DL   = 5;
   localparam int WIN  = 32;
   localparam int MAXV = 31;

   logic          clk;
   logic          reset_s;
   logic          pdm_in_s;
   logic          pdm_valid_s;
   logic          sync_s;
   logic          ready_s;
   logic [DL-1:0] sample_out_s;
   logic          sample_valid_s;
   logic          overrun_s;

   int n_cmp;
   int n_err;
   int n_vcyc;
   int last_out;
   int cyc;
   int first_vcyc;

   // reference model state
   int m_win;
   int m_ones;
   int m_out;
   int m_valid;
   int m_ovr;

   pdm_demod #(.DEC_LOG2(DL)) dut (
      .clk          (clk),
      .reset        (reset_s),
      .pdm_in       (pdm_in_s),
      .pdm_valid    (pdm_valid_s),
      .sync         (sync_s),
      .sample_out   (sample_out_s),
      .sample_valid (sample_valid_s),
      .sample_ready (ready_s),
      .overrun      (overrun_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // One clock: update the model from the inputs sampled at this edge, then compare.
   task automatic step();
      int load;
      int news;
      @(posedge clk);
      load = 0;
      news = 0;
      if (reset_s) begin
         m_win = 0; m_ones = 0; m_out = 0; m_valid = 0; m_ovr = 0;
      end else begin
         if (sync_s) begin
            m_win  = pdm_valid_s ? 1 : 0;
            m_ones = pdm_valid_s ? int'(pdm_in_s) : 0;
         end else if (pdm_valid_s) begin
            m_win++;
            m_ones += int'(pdm_in_s);
            if (m_win == WIN) begin
               load   = 1;
               news   = (m_ones > MAXV) ? MAXV : m_ones;
               m_win  = 0;
               m_ones = 0;
            end
         end
         if (load != 0) begin
            if (m_valid != 0 && !ready_s) m_ovr = 1;
            m_out   = news;
            m_valid = 1;
         end else if (m_valid != 0 && ready_s) begin
            m_valid = 0;
         end
      end
      #1;
      chk("sample_out", sample_out_s, m_out);
      chk("sample_valid", sample_valid_s, m_valid);
      chk("overrun", overrun_s, m_ovr);
      if (sample_valid_s) begin
         if (n_vcyc == 0) first_vcyc = cyc;
         n_vcyc++;
         last_out = int'(sample_out_s);
      end
      cyc++;
   endtask

   task automatic drive(input logic v, input logic b, input logic s, input logic r);
      pdm_valid_s = v;
      pdm_in_s    = b;
      sync_s      = s;
      ready_s     = r;
      reset_s     = 1'b0;
      step();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic clear_tally();
      n_vcyc     = 0;
      last_out   = -1;
      cyc        = 0;
      first_vcyc = -1;
   endtask

   // First-order PDM modulator model: the carry out of a 5-bit accumulator.
   task automatic run_mod(input int code, input int nwin);
      int acc;
      int sum;
      acc = 0;
      clear_tally();
      for (int i = 0; i < nwin * WIN; i++) begin
         sum = acc + code;
         acc = sum % 32;
         drive(1'b1, (sum >= 32) ? 1'b1 : 1'b0, (i == 0) ? 1'b1 : 1'b0, 1'b1);
         if (sample_valid_s) chk("mod_code", sample_out_s, code);
      end
      chk("mod_count", n_vcyc, nwin);
   endtask

   // Window of 32 qualified bits where the first k bits are ones.
   task automatic window_k(input int k, input logic r, input logic r_last);
      for (int i = 0; i < WIN; i++)
         drive(1'b1, (i < k) ? 1'b1 : 1'b0, 1'b0, (i == WIN - 1) ? r_last : r);
   endtask

   initial begin
      int bits [WIN];
      int j;
      int t;
      n_cmp = 0; n_err = 0;
      m_win = 0; m_ones = 0; m_out = 0; m_valid = 0; m_ovr = 0;
      clear_tally();
      pdm_in_s = 1'b0; pdm_valid_s = 1'b0; sync_s = 1'b0; ready_s = 1'b1; reset_s = 1'b1;

      // reset for 2 cycles with random inputs
      for (int i = 0; i < 2; i++) begin
         reset_s = 1'b1;
         pdm_in_s = 1'($urandom); pdm_valid_s = 1'($urandom);
         step();
      end
      chk("rst_out", sample_out_s, 0);
      chk("rst_valid", sample_valid_s, 0);
      chk("rst_ovr", overrun_s, 0);

      // 31 qualified bits: no sample yet; the 32nd produces 31 (all ones, saturated)
      clear_tally();
      for (int i = 0; i < WIN - 1; i++) drive(1'b1, 1'b1, 1'b0, 1'b1);
      chk("no_early_sample", n_vcyc, 0);
      drive(1'b1, 1'b1, 1'b0, 1'b1);
      chk("all_ones_out", sample_out_s, MAXV);
      idle(3);
      chk("all_ones_pulse", n_vcyc, 1);

      // all zeros
      clear_tally();
      drive(1'b1, 1'b0, 1'b1, 1'b1);
      for (int i = 1; i < WIN; i++) drive(1'b1, 1'b0, 1'b0, 1'b1);
      idle(3);
      chk("all_zeros_pulse", n_vcyc, 1);
      chk("all_zeros_out", last_out, 0);

      // modulator stream, aligned with sync
      run_mod(10, 3);
      run_mod(0, 2);
      run_mod(1, 2);
      run_mod(17, 2);
      run_mod(31, 2);
      idle(2);

      // pdm_valid alternating, 16 of 32 qualified bits set in random order
      for (int i = 0; i < WIN; i++) bits[i] = (i < 16) ? 1 : 0;
      for (int i = WIN - 1; i > 0; i--) begin
         j = int'($urandom_range(i, 0));
         t = bits[i]; bits[i] = bits[j]; bits[j] = t;
      end
      drive(1'b0, 1'b0, 1'b1, 1'b1);
      clear_tally();
      for (int i = 0; i < 2 * WIN; i++) begin
         if (i % 2 == 0) drive(1'b1, bits[i/2] != 0, 1'b0, 1'b1);
         else            drive(1'b0, 1'($urandom), 1'b0, 1'b1);
      end
      chk("alt_count", n_vcyc, 1);
      chk("alt_out", last_out, 16);
      chk("alt_latency", first_vcyc, 2 * WIN - 2);

      // backpressure across two windows: newest wins, overrun sticky until reset
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      window_k(5, 1'b0, 1'b0);
      chk("bp_first", sample_out_s, 5);
      chk("bp_first_ovr", overrun_s, 0);
      window_k(9, 1'b0, 1'b0);
      chk("bp_out", sample_out_s, 9);
      chk("bp_valid", sample_valid_s, 1);
      chk("bp_ovr", overrun_s, 1);
      idle(5);
      chk("bp_ovr_held", overrun_s, 1);
      reset_s = 1'b1; step();
      chk("bp_ovr_reset", overrun_s, 0);

      // ready high on the load edge: no overrun
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      window_k(7, 1'b0, 1'b0);
      window_k(3, 1'b0, 1'b1);
      chk("rdy_load_out", sample_out_s, 3);
      chk("rdy_load_valid", sample_valid_s, 1);
      chk("rdy_load_ovr", overrun_s, 0);
      idle(2);

      // sync after 10 qualified bits discards them; new window starts at the sync bit
      drive(1'b0, 1'b0, 1'b1, 1'b1);
      clear_tally();
      for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, 1'b0, 1'b1);
      drive(1'b1, 1'b1, 1'b1, 1'b1);
      for (int i = 1; i < WIN; i++) drive(1'b1, (i <= 11) ? 1'b1 : 1'b0, 1'b0, 1'b1);
      idle(2);
      chk("sync_count", n_vcyc, 1);
      chk("sync_out", last_out, 12);

      // reset at bit 20 with a pending sample: everything returns to reset values
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      window_k(WIN, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) drive(1'b1, 1'($urandom), 1'b0, 1'b0);
      reset_s = 1'b1; pdm_valid_s = 1'($urandom); pdm_in_s = 1'($urandom); sync_s = 1'b0;
      step();
      chk("mid_rst_out", sample_out_s, 0);
      chk("mid_rst_valid", sample_valid_s, 0);
      chk("mid_rst_ovr", overrun_s, 0);
      clear_tally();
      for (int i = 0; i < WIN; i++) drive(1'b1, 1'b1, 1'b0, 1'b1);
      idle(2);
      chk("mid_rst_full", last_out, MAXV);
      chk("mid_rst_count", n_vcyc, 1);

      // randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         pdm_valid_s = ($urandom_range(3, 0) != 0);
         pdm_in_s    = 1'($urandom);
         sync_s      = ($urandom_range(63, 0) == 0);
         ready_s     = ($urandom_range(3, 0) != 0);
         reset_s     = ($urandom_range(499, 0) == 0);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
